// File: rtl/ws2812_tx_if.sv
// Frame-buffer side of the WS2812 encoder: LED address out, colour of that LED in.
// Handshake: data_request pulses one cycle; the colour for `address` must be
// valid in the very next cycle, which is the only cycle the encoder samples it.
interface ws2812_tx_if #(
    parameter int AW = 8
);
    logic          reset_state;
    logic          data_request;
    logic          new_address;
    logic [AW-1:0] address;
    logic [7:0]    red_in;
    logic [7:0]    green_in;
    logic [7:0]    blue_in;

    modport master (
        output reset_state, data_request, new_address, address,
        input  red_in, green_in, blue_in
    );

    modport slave (
        input  reset_state, data_request, new_address, address,
        output red_in, green_in, blue_in
    );
endinterface

// File: rtl/ws2812_tx.sv
// WS2812 serial encoder: fetches one GRB colour per LED, shifts it out MSB-first
// as timed high/low pulses, then holds DO low for the latch period.
module ws2812_tx #(
    parameter int NUM_LEDS     = 256,
    parameter int SYSTEM_CLOCK = 50000000,
    parameter int T0H_NS       = 350,
    parameter int T1H_NS       = 700,
    parameter int BIT_NS       = 1250,
    parameter int RESET_NS     = 60000
) (
    input  logic               CLK,
    input  logic               RST_N,
    ws2812_tx_if.master        fb,
    output logic               DO,
    output logic [1:0]         state_dbg
);
    localparam int AW        = $clog2(NUM_LEDS);
    localparam int CYC_PER_US = SYSTEM_CLOCK / 1000000;
    localparam int T0H_CYC   = CYC_PER_US * T0H_NS / 1000;
    localparam int T1H_CYC   = CYC_PER_US * T1H_NS / 1000;
    localparam int BIT_CYC   = CYC_PER_US * BIT_NS / 1000;
    localparam int RESET_CYC = CYC_PER_US * RESET_NS / 1000;
    localparam int TW        = $clog2(RESET_CYC);
    localparam int PW        = $clog2(BIT_CYC);

    localparam logic [TW-1:0] RESET_LAST = TW'(RESET_CYC - 1);
    localparam logic [PW-1:0] BIT_LAST   = PW'(BIT_CYC - 1);
    localparam logic [PW-1:0] T0H_P      = PW'(T0H_CYC);
    localparam logic [PW-1:0] T1H_P      = PW'(T1H_CYC);
    localparam logic [AW-1:0] LAST_ADDR  = AW'(NUM_LEDS - 1);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_REQ   = 2'd1,
        S_LATCH = 2'd2,
        S_BITS  = 2'd3
    } state_t;

    state_t        state, state_next;
    logic [TW-1:0] timer, timer_next;
    logic [PW-1:0] phase, phase_next;
    logic [4:0]    bit_cnt, bit_next;
    logic [23:0]   shift, shift_next;
    logic [AW-1:0] address, address_next;
    logic          last, last_next;
    logic          do_q, do_next;
    logic          data_request, data_request_next;
    logic          new_address, new_address_next;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= S_RESET;
            timer        <= '0;
            phase        <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            address      <= '0;
            last         <= 1'b0;
            do_q         <= 1'b0;
            data_request <= 1'b0;
            new_address  <= 1'b0;
        end else begin
            state        <= state_next;
            timer        <= timer_next;
            phase        <= phase_next;
            bit_cnt      <= bit_next;
            shift        <= shift_next;
            address      <= address_next;
            last         <= last_next;
            do_q         <= do_next;
            data_request <= data_request_next;
            new_address  <= new_address_next;
        end
    end

    always_comb begin
        state_next       = state;
        timer_next       = timer;
        phase_next       = phase;
        bit_next         = bit_cnt;
        shift_next       = shift;
        address_next     = address;
        last_next        = last;
        do_next          = 1'b0;
        new_address_next = 1'b0;

        case (state)
            S_RESET: begin
                if (timer == RESET_LAST) begin
                    timer_next = '0;
                    state_next = S_REQ;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            S_REQ: begin
                state_next = S_LATCH;
            end
            S_LATCH: begin
                shift_next       = {fb.green_in, fb.red_in, fb.blue_in};
                last_next        = (address == LAST_ADDR);
                address_next     = (address == LAST_ADDR) ? '0 : address + 1'b1;
                new_address_next = 1'b1;
                bit_next         = '0;
                phase_next       = '0;
                state_next       = S_BITS;
            end
            S_BITS: begin
                // High time is chosen by the bit currently at the top of the shifter.
                do_next = (phase < (shift[23] ? T1H_P : T0H_P));
                if (phase == BIT_LAST) begin
                    phase_next = '0;
                    shift_next = {shift[22:0], 1'b0};
                    bit_next   = bit_cnt + 5'd1;
                    if (bit_cnt == 5'd23) begin
                        state_next = last ? S_RESET : S_REQ;
                    end
                end else begin
                    phase_next = phase + 1'b1;
                end
            end
            default: begin
                state_next = S_RESET;
            end
        endcase

        // Registered from the next state so the pulse coincides with S_REQ itself.
        data_request_next = (state_next == S_REQ);
    end

    assign fb.reset_state  = (state == S_RESET);
    assign fb.data_request = data_request;
    assign fb.new_address  = new_address;
    assign fb.address      = address;
    assign DO              = do_q;
    assign state_dbg       = state;
endmodule

// File: tb/tb_ws2812_tx.sv
// Bench for ws2812_tx with 4 LEDs at 50 MHz: every cycle's outputs are compared
// against a frame-timing model built from the protocol's cycle arithmetic.
module tb_ws2812_tx;
    localparam int N     = 4;
    localparam int AW    = 2;
    localparam int RST   = 3000;
    localparam int BITC  = 62;
    localparam int T0    = 17;
    localparam int T1    = 35;
    localparam int LED_P = 2 + 24 * BITC;
    localparam int F     = RST + N * LED_P;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       do_o;
    logic [1:0] state_dbg;

    ws2812_tx_if #(.AW(AW)) fb ();

    ws2812_tx #(.NUM_LEDS(N)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .fb        (fb.master),
        .DO        (do_o),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          g0 = 0;
    bit          aborted = 1'b0;
    logic [23:0] col_tab [64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected {DO, reset_state, data_request, new_address, address} in cycle t after release.
    function automatic logic [AW+3:0] expect_at(input int t);
        int f, fi, u, led, o, s, fs, fsi, b, p, lat;
        logic d, rs, dr, na;
        logic [23:0] c;
        fi  = t / F;
        f   = t % F;
        rs  = (f < RST);
        dr  = 1'b0;
        na  = 1'b0;
        lat = fi * N;
        if (!rs) begin
            u   = f - RST;
            led = u / LED_P;
            o   = u % LED_P;
            dr  = (o == 0);
            na  = (o == 2);
            lat = lat + led + ((o >= 2) ? 1 : 0);
        end
        d = 1'b0;
        if (t > 0) begin
            s   = t - 1;
            fsi = s / F;
            fs  = s % F;
            if (fs >= RST) begin
                u   = fs - RST;
                led = u / LED_P;
                o   = u % LED_P;
                if (o >= 2) begin
                    b = (o - 2) / BITC;
                    p = (o - 2) % BITC;
                    c = col_tab[g0 + fsi * N + led];
                    d = (p < (c[23 - b] ? T1 : T0));
                end
            end
        end
        return {d, rs, dr, na, AW'(lat % N)};
    endfunction

    // LED table slot latched in cycle t, or -1 when t is not a sampling cycle.
    function automatic int latch_slot(input int t);
        int f, u;
        f = t % F;
        if (f < RST) return -1;
        u = f - RST;
        if ((u % LED_P) != 1) return -1;
        return g0 + (t / F) * N + u / LED_P;
    endfunction

    function automatic bit one_bit_phase10(input int t);
        int f, u, o, b, p;
        logic [23:0] c;
        f = t % F;
        if (f < RST) return 1'b0;
        u = f - RST;
        o = u % LED_P;
        if (o < 2) return 1'b0;
        b = (o - 2) / BITC;
        p = (o - 2) % BITC;
        c = col_tab[g0 + (t / F) * N + u / LED_P];
        return (p == 10) && c[23 - b];
    endfunction

    task automatic drive_noise();
        fb.green_in = 8'($urandom_range(0, 255));
        fb.red_in   = 8'($urandom_range(0, 255));
        fb.blue_in  = 8'($urandom_range(0, 255));
    endtask

    task automatic check_reset_hold(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("rst_hold", {do_o, fb.reset_state, fb.data_request, fb.new_address, fb.address},
                  {1'b0, 1'b1, 1'b0, 1'b0, {AW{1'b0}}});
            check("rst_state_dbg", state_dbg, 2'd0);
            drive_noise();
        end
    endtask

    task automatic run(input int cycles, input bit abort_mid);
        int slot;
        int dr_cnt;
        dr_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < cycles; t++) begin
            if (t > 0) @(negedge clk);
            check("outputs", {do_o, fb.reset_state, fb.data_request, fb.new_address, fb.address},
                  expect_at(t));
            if (t < F && fb.data_request) dr_cnt++;
            if (t == F) check("dr_per_frame", dr_cnt, N);
            slot = latch_slot(t);
            if (slot >= 0) begin
                col_tab[slot] = (slot == 0) ? 24'hA50F80 : 24'($urandom);
                {fb.green_in, fb.red_in, fb.blue_in} = col_tab[slot];
            end else begin
                drive_noise();
            end
            if (abort_mid && t >= 2 * F && one_bit_phase10(t)) begin
                rst_n = 1'b0;
                #1;
                check("async_do", do_o, 1'b0);
                check("async_addr", fb.address, 0);
                check("async_reset_state", fb.reset_state, 1'b1);
                aborted = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        drive_noise();
        check_reset_hold(3);

        g0 = 0;
        run(2 * F + 4000, 1'b1);
        check("abort_reached", aborted, 1'b1);
        rst_n = 1'b0;

        check_reset_hold(3);
        g0 = 16;
        run(F + 1600, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
